// File: rtl/query_dispatch_scheduler.sv
// rtl/query_dispatch_scheduler.sv - round-robin dispatch of queries and their blocks to idle engines
module query_dispatch_scheduler #(
    parameter int NUM_PES     = 64,
    parameter int NUM_ENGINES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     query_info_valid_in,
    output logic                     query_info_rdy_out,
    input  logic [24:0]              ref_length_in,
    input  logic [24:0]              ref_addr_in,
    input  logic [15:0]              num_query_blocks_in,
    input  logic [NUM_PES*2-1:0]     query_seq_block_in,
    input  logic                     query_seq_block_valid_in,
    output logic                     query_seq_block_rdy_out,
    output logic [24:0]              eng_ref_length_out,
    output logic [24:0]              eng_ref_addr_out,
    output logic [15:0]              eng_num_query_blocks_out,
    output logic [NUM_ENGINES-1:0]   eng_query_info_valid_out,
    input  logic [NUM_ENGINES-1:0]   eng_query_info_rdy_in,
    output logic [NUM_PES*2-1:0]     eng_query_seq_block_out,
    output logic [NUM_ENGINES-1:0]   eng_query_seq_block_valid_out,
    input  logic [NUM_ENGINES-1:0]   eng_query_seq_block_rdy_in,
    input  logic [NUM_ENGINES-1:0]   eng_done_in,
    output logic [NUM_ENGINES-1:0]   eng_busy_out,
    output logic [31:0]              queries_dispatched_out
);

    localparam int SEL_W = $clog2(NUM_ENGINES);

    typedef enum logic [1:0] {IDLE, ARB, SEND_INFO, SEND_BLOCKS} state_t;

    state_t                 state_q, state_d;
    logic [NUM_ENGINES-1:0] busy_q, busy_d;
    logic [NUM_ENGINES-1:0] info_valid_q, info_valid_d;
    logic [SEL_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [15:0]            blk_cnt_q, blk_cnt_d;
    logic [31:0]            dispatched_q, dispatched_d;
    logic [24:0]            ref_len_q, ref_len_d;
    logic [24:0]            ref_addr_q, ref_addr_d;
    logic [15:0]            num_blk_q, num_blk_d;
    logic                   init_q, init_d;

    logic                   grant_found;
    logic [SEL_W-1:0]       grant_idx;
    logic [SEL_W-1:0]       cand;

    // First idle engine at or after rr_ptr, wrapping modulo NUM_ENGINES.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            cand = SEL_W'((int'(rr_ptr_q) + k) % NUM_ENGINES);
            if (!grant_found && !busy_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign query_info_rdy_out = init_q && (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        info_valid_d = info_valid_q;
        rr_ptr_d     = rr_ptr_q;
        sel_d        = sel_q;
        blk_cnt_d    = blk_cnt_q;
        dispatched_d = dispatched_q;
        ref_len_d    = ref_len_q;
        ref_addr_d   = ref_addr_q;
        num_blk_d    = num_blk_q;
        init_d       = 1'b1;
        // Done clears first so a same-cycle grant handshake below can override it.
        busy_d       = busy_q & ~eng_done_in;
        case (state_q)
            IDLE: begin
                if (query_info_valid_in && query_info_rdy_out) begin
                    ref_len_d  = ref_length_in;
                    ref_addr_d = ref_addr_in;
                    num_blk_d  = num_query_blocks_in;
                    state_d    = ARB;
                end
            end
            ARB: begin
                if (grant_found) begin
                    sel_d        = grant_idx;
                    rr_ptr_d     = SEL_W'((int'(grant_idx) + 1) % NUM_ENGINES);
                    info_valid_d = {{(NUM_ENGINES-1){1'b0}}, 1'b1} << grant_idx;
                    state_d      = SEND_INFO;
                end
            end
            SEND_INFO: begin
                if (eng_query_info_rdy_in[sel_q]) begin
                    busy_d[sel_q] = 1'b1;
                    blk_cnt_d     = '0;
                    info_valid_d  = '0;
                    if (num_blk_q == 16'd0) begin
                        dispatched_d = dispatched_q + 32'd1;
                        state_d      = IDLE;
                    end else begin
                        state_d = SEND_BLOCKS;
                    end
                end
            end
            SEND_BLOCKS: begin
                if (query_seq_block_valid_in && eng_query_seq_block_rdy_in[sel_q]) begin
                    blk_cnt_d = blk_cnt_q + 16'd1;
                    if (blk_cnt_q == num_blk_q - 16'd1) begin
                        dispatched_d = dispatched_q + 32'd1;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            info_valid_q <= '0;
            busy_q       <= '0;
            rr_ptr_q     <= '0;
            sel_q        <= '0;
            blk_cnt_q    <= '0;
            dispatched_q <= '0;
            ref_len_q    <= '0;
            ref_addr_q   <= '0;
            num_blk_q    <= '0;
            init_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            info_valid_q <= info_valid_d;
            busy_q       <= busy_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            blk_cnt_q    <= blk_cnt_d;
            dispatched_q <= dispatched_d;
            ref_len_q    <= ref_len_d;
            ref_addr_q   <= ref_addr_d;
            num_blk_q    <= num_blk_d;
            init_q       <= init_d;
        end
    end

    // Block path is a pure pass-through to the selected engine, no added latency.
    always_comb begin
        eng_query_seq_block_valid_out = '0;
        query_seq_block_rdy_out       = 1'b0;
        if (state_q == SEND_BLOCKS) begin
            eng_query_seq_block_valid_out[sel_q] = query_seq_block_valid_in;
            query_seq_block_rdy_out              = eng_query_seq_block_rdy_in[sel_q];
        end
    end

    assign eng_query_seq_block_out  = query_seq_block_in;
    assign eng_query_info_valid_out = info_valid_q;
    assign eng_ref_length_out       = ref_len_q;
    assign eng_ref_addr_out         = ref_addr_q;
    assign eng_num_query_blocks_out = num_blk_q;
    assign eng_busy_out             = busy_q;
    assign queries_dispatched_out   = dispatched_q;

endmodule

// File: tb/tb_query_dispatch_scheduler.sv
// tb/tb_query_dispatch_scheduler.sv - directed self-checking bench for query_dispatch_scheduler
module tb_query_dispatch_scheduler;

    localparam int NP = 64;
    localparam int NE = 4;
    localparam int BW = NP * 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           query_info_valid_in;
    logic           query_info_rdy_out;
    logic [24:0]    ref_length_in;
    logic [24:0]    ref_addr_in;
    logic [15:0]    num_query_blocks_in;
    logic [BW-1:0]  query_seq_block_in;
    logic           query_seq_block_valid_in;
    logic           query_seq_block_rdy_out;
    logic [24:0]    eng_ref_length_out;
    logic [24:0]    eng_ref_addr_out;
    logic [15:0]    eng_num_query_blocks_out;
    logic [NE-1:0]  eng_query_info_valid_out;
    logic [NE-1:0]  eng_query_info_rdy_in;
    logic [BW-1:0]  eng_query_seq_block_out;
    logic [NE-1:0]  eng_query_seq_block_valid_out;
    logic [NE-1:0]  eng_query_seq_block_rdy_in;
    logic [NE-1:0]  eng_done_in;
    logic [NE-1:0]  eng_busy_out;
    logic [31:0]    queries_dispatched_out;

    int vectors = 0;
    int miscompares = 0;

    int            rx_eng[$];
    logic [BW-1:0] rx_data[$];

    query_dispatch_scheduler #(.NUM_PES(NP), .NUM_ENGINES(NE)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .query_info_valid_in           (query_info_valid_in),
        .query_info_rdy_out            (query_info_rdy_out),
        .ref_length_in                 (ref_length_in),
        .ref_addr_in                   (ref_addr_in),
        .num_query_blocks_in           (num_query_blocks_in),
        .query_seq_block_in            (query_seq_block_in),
        .query_seq_block_valid_in      (query_seq_block_valid_in),
        .query_seq_block_rdy_out       (query_seq_block_rdy_out),
        .eng_ref_length_out            (eng_ref_length_out),
        .eng_ref_addr_out              (eng_ref_addr_out),
        .eng_num_query_blocks_out      (eng_num_query_blocks_out),
        .eng_query_info_valid_out      (eng_query_info_valid_out),
        .eng_query_info_rdy_in         (eng_query_info_rdy_in),
        .eng_query_seq_block_out       (eng_query_seq_block_out),
        .eng_query_seq_block_valid_out (eng_query_seq_block_valid_out),
        .eng_query_seq_block_rdy_in    (eng_query_seq_block_rdy_in),
        .eng_done_in                   (eng_done_in),
        .eng_busy_out                  (eng_busy_out),
        .queries_dispatched_out        (queries_dispatched_out)
    );

    always #5 clk = ~clk;

    // Engine-side transfer log; inputs are stable from negedge to the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            for (int e = 0; e < NE; e++) begin
                if (eng_query_seq_block_valid_out[e] && eng_query_seq_block_rdy_in[e]) begin
                    rx_eng.push_back(e);
                    rx_data.push_back(eng_query_seq_block_out);
                end
            end
        end
    end

    function automatic logic [BW-1:0] blk_pat(input int i);
        return {{(BW-32){1'b0}}, 32'hB10C0000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_info(input logic [24:0] len, input logic [24:0] addr,
                              input logic [15:0] nb, output bit ok);
        ok = 1'b0;
        query_info_valid_in = 1'b1;
        ref_length_in       = len;
        ref_addr_in         = addr;
        num_query_blocks_in = nb;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (query_info_rdy_out) ok = 1'b1;
            tick();
        end
        query_info_valid_in = 1'b0;
    endtask

    task automatic wait_grant(output int eng, output bit ok);
        eng = -1;
        ok  = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (eng_query_info_valid_out != '0) begin
                ok = 1'b1;
                for (int e = 0; e < NE; e++)
                    if (eng_query_info_valid_out[e]) eng = e;
            end
            tick();
        end
    endtask

    task automatic push_blocks(input int n, output int got);
        got = 0;
        query_seq_block_valid_in = 1'b1;
        query_seq_block_in       = blk_pat(0);
        for (int i = 0; i < 40 && got < n; i++) begin
            @(negedge clk);
            if (query_seq_block_rdy_out) got++;
            tick();
            query_seq_block_in = blk_pat(got);
        end
        query_seq_block_valid_in = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();
        rx_eng.delete();
        rx_data.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (query_info_rdy_out !== 1'b0 || query_seq_block_rdy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rdy: got info=%b blk=%b expected 0 0", query_info_rdy_out, query_seq_block_rdy_out);
        end
        vectors++;
        if (eng_busy_out !== 4'b0000 || queries_dispatched_out !== 32'd0 || eng_query_info_valid_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b qd=%0d ivalid=%b expected 0000 0 0000",
                     eng_busy_out, queries_dispatched_out, eng_query_info_valid_out);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (query_info_rdy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL rdy_first_cycle: got %b expected 0", query_info_rdy_out);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (query_info_rdy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL rdy_after_init: got %b expected 1", query_info_rdy_out);
        end
        tick();
    endtask

    task automatic test_single_query();
        bit ok;
        int got;
        eng_query_info_rdy_in = 4'b0000;
        rx_eng.delete();
        rx_data.delete();
        issue_info(25'd100, 25'h40, 16'd3, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_accept: got timeout expected accept");
        end
        @(negedge clk);
        vectors++;
        if (eng_query_info_valid_out !== 4'b0000 || query_info_rdy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL single_arb_cycle: got ivalid=%b rdy=%b expected 0000 0", eng_query_info_valid_out, query_info_rdy_out);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (eng_query_info_valid_out !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_info_valid: got %b expected 0001", eng_query_info_valid_out);
        end
        vectors++;
        if (eng_ref_length_out !== 25'd100 || eng_ref_addr_out !== 25'h40 || eng_num_query_blocks_out !== 16'd3) begin
            miscompares++;
            $display("FAIL single_info_regs: got len=%0d addr=%h nb=%0d expected 100 40 3",
                     eng_ref_length_out, eng_ref_addr_out, eng_num_query_blocks_out);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (eng_query_info_valid_out !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_valid_hold: got %b expected 0001", eng_query_info_valid_out);
        end
        eng_query_info_rdy_in = 4'b1111;
        tick();
        @(negedge clk);
        vectors++;
        if (eng_busy_out !== 4'b0001 || eng_query_info_valid_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_busy: got busy=%b ivalid=%b expected 0001 0000", eng_busy_out, eng_query_info_valid_out);
        end
        tick();
        push_blocks(3, got);
        @(negedge clk);
        vectors++;
        if (rx_eng.size() !== 3 || got !== 3) begin
            miscompares++;
            $display("FAIL single_blk_count: got eng=%0d up=%0d expected 3 3", rx_eng.size(), got);
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (rx_eng[i] !== 0 || rx_data[i] !== blk_pat(i)) begin
                    miscompares++;
                    $display("FAIL single_blk_%0d: got eng=%0d data=%h expected 0 %h", i, rx_eng[i], rx_data[i], blk_pat(i));
                end
            end
        end
        vectors++;
        if (queries_dispatched_out !== 32'd1 || query_info_rdy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done: got qd=%0d rdy=%b expected 1 1", queries_dispatched_out, query_info_rdy_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit ok2;
        int eng;
        int got;
        apply_reset();
        for (int q = 0; q < 4; q++) begin
            issue_info(25'(q * 10 + 1), 25'(q), 16'd1, ok);
            wait_grant(eng, ok2);
            push_blocks(1, got);
            vectors++;
            if (!ok || !ok2 || eng !== q || got !== 1) begin
                miscompares++;
                $display("FAIL b2b_grant_%0d: got eng=%0d ok=%b%b blk=%0d expected eng=%0d ok=11 blk=1", q, eng, ok, ok2, got, q);
            end
        end
        @(negedge clk);
        vectors++;
        if (eng_busy_out !== 4'b1111 || queries_dispatched_out !== 32'd4) begin
            miscompares++;
            $display("FAIL b2b_busy: got busy=%b qd=%0d expected 1111 4", eng_busy_out, queries_dispatched_out);
        end
        tick();
        issue_info(25'd55, 25'h55, 16'd1, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (eng_query_info_valid_out !== 4'b0000 || eng_query_seq_block_valid_out !== 4'b0000 ||
                query_info_rdy_out !== 1'b0 || query_seq_block_rdy_out !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_stall_%0d: got ivalid=%b bvalid=%b rdy=%b%b expected 0000 0000 00", i,
                         eng_query_info_valid_out, eng_query_seq_block_valid_out, query_info_rdy_out, query_seq_block_rdy_out);
            end
            tick();
        end
        @(negedge clk);
        eng_done_in = 4'b0100;
        tick();
        eng_done_in = 4'b0000;
        wait_grant(eng, ok2);
        vectors++;
        if (!ok2 || eng !== 2) begin
            miscompares++;
            $display("FAIL b2b_fifth_grant: got eng=%0d expected 2", eng);
        end
        rx_eng.delete();
        rx_data.delete();
        push_blocks(1, got);
        @(negedge clk);
        vectors++;
        if (rx_eng.size() !== 1 || eng_busy_out !== 4'b1111 || queries_dispatched_out !== 32'd5) begin
            miscompares++;
            $display("FAIL b2b_fifth_done: got rx=%0d busy=%b qd=%0d expected 1 1111 5",
                     rx_eng.size(), eng_busy_out, queries_dispatched_out);
        end else if (rx_eng[0] !== 2) begin
            vectors++;
            miscompares++;
            $display("FAIL b2b_fifth_route: got eng=%0d expected 2", rx_eng[0]);
        end
        tick();
    endtask

    task automatic test_zero_blocks();
        bit ok;
        bit ok2;
        int eng;
        @(negedge clk);
        eng_done_in = 4'b1111;
        tick();
        eng_done_in = 4'b0000;
        rx_eng.delete();
        rx_data.delete();
        issue_info(25'd7, 25'h700, 16'd0, ok);
        wait_grant(eng, ok2);
        vectors++;
        if (!ok || !ok2 || eng !== 3) begin
            miscompares++;
            $display("FAIL zero_grant: got eng=%0d expected 3", eng);
        end
        @(negedge clk);
        vectors++;
        if (query_info_rdy_out !== 1'b1 || queries_dispatched_out !== 32'd6 || eng_busy_out !== 4'b1000) begin
            miscompares++;
            $display("FAIL zero_done: got rdy=%b qd=%0d busy=%b expected 1 6 1000",
                     query_info_rdy_out, queries_dispatched_out, eng_busy_out);
        end
        vectors++;
        if (rx_eng.size() !== 0 || query_seq_block_rdy_out !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_no_blocks: got rx=%0d brdy=%b expected 0 0", rx_eng.size(), query_seq_block_rdy_out);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        bit ok2;
        int eng;
        rx_eng.delete();
        rx_data.delete();
        issue_info(25'd9, 25'h900, 16'd4, ok);
        wait_grant(eng, ok2);
        vectors++;
        if (!ok || !ok2 || eng !== 0) begin
            miscompares++;
            $display("FAIL bp_grant: got eng=%0d expected 0", eng);
        end
        query_seq_block_valid_in = 1'b1;
        query_seq_block_in       = blk_pat(0);
        @(negedge clk);
        tick();
        query_seq_block_in         = blk_pat(1);
        eng_query_seq_block_rdy_in = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (query_seq_block_rdy_out !== 1'b0 || eng_query_seq_block_valid_out !== 4'b0001) begin
                miscompares++;
                $display("FAIL bp_stall_%0d: got brdy=%b bvalid=%b expected 0 0001", i,
                         query_seq_block_rdy_out, eng_query_seq_block_valid_out);
            end
            tick();
        end
        eng_query_seq_block_rdy_in = 4'b1111;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            tick();
            query_seq_block_in = blk_pat(i + 1);
        end
        query_seq_block_valid_in = 1'b0;
        @(negedge clk);
        vectors++;
        if (rx_eng.size() !== 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d expected 4", rx_eng.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rx_eng[i] !== 0 || rx_data[i] !== blk_pat(i)) begin
                    miscompares++;
                    $display("FAIL bp_blk_%0d: got eng=%0d data=%h expected 0 %h", i, rx_eng[i], rx_data[i], blk_pat(i));
                end
            end
        end
        vectors++;
        if (queries_dispatched_out !== 32'd7 || eng_busy_out !== 4'b1001 || query_info_rdy_out !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_done: got qd=%0d busy=%b rdy=%b expected 7 1001 1",
                     queries_dispatched_out, eng_busy_out, query_info_rdy_out);
        end
        tick();
    endtask

    task automatic test_set_wins();
        bit ok;
        bit seen;
        eng_query_info_rdy_in = 4'b0000;
        issue_info(25'd11, 25'hB00, 16'd0, ok);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (eng_query_info_valid_out != '0) seen = 1'b1;
            else tick();
        end
        vectors++;
        if (!ok || eng_query_info_valid_out !== 4'b0010) begin
            miscompares++;
            $display("FAIL sw_grant: got ivalid=%b expected 0010", eng_query_info_valid_out);
        end
        eng_done_in           = 4'b0010;
        eng_query_info_rdy_in = 4'b1111;
        tick();
        eng_done_in = 4'b0000;
        @(negedge clk);
        vectors++;
        if (eng_busy_out !== 4'b1011 || queries_dispatched_out !== 32'd8) begin
            miscompares++;
            $display("FAIL sw_set_wins: got busy=%b qd=%0d expected 1011 8", eng_busy_out, queries_dispatched_out);
        end
        eng_done_in = 4'b0100;
        tick();
        eng_done_in = 4'b0000;
        @(negedge clk);
        vectors++;
        if (eng_busy_out !== 4'b1011) begin
            miscompares++;
            $display("FAIL sw_idle_done: got busy=%b expected 1011", eng_busy_out);
        end
        eng_done_in = 4'b1000;
        tick();
        eng_done_in = 4'b0000;
        @(negedge clk);
        vectors++;
        if (eng_busy_out !== 4'b0011) begin
            miscompares++;
            $display("FAIL sw_busy_done: got busy=%b expected 0011", eng_busy_out);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit ok2;
        int eng;
        int got;
        rx_eng.delete();
        rx_data.delete();
        issue_info(25'd13, 25'hD00, 16'd5, ok);
        wait_grant(eng, ok2);
        push_blocks(2, got);
        vectors++;
        if (!ok || !ok2 || eng !== 2 || got !== 2) begin
            miscompares++;
            $display("FAIL rm_setup: got eng=%0d blk=%0d expected 2 2", eng, got);
        end
        query_seq_block_valid_in = 1'b1;
        query_seq_block_in       = blk_pat(2);
        @(negedge clk);
        vectors++;
        if (eng_query_seq_block_valid_out !== 4'b0100 || query_seq_block_rdy_out !== 1'b1 || eng_busy_out !== 4'b0111) begin
            miscompares++;
            $display("FAIL rm_mid: got bvalid=%b brdy=%b busy=%b expected 0100 1 0111",
                     eng_query_seq_block_valid_out, query_seq_block_rdy_out, eng_busy_out);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (eng_query_seq_block_valid_out !== 4'b0000 || query_seq_block_rdy_out !== 1'b0 ||
            query_info_rdy_out !== 1'b0 || eng_query_info_valid_out !== 4'b0000) begin
            miscompares++;
            $display("FAIL rm_outputs: got bvalid=%b brdy=%b irdy=%b ivalid=%b expected 0000 0 0 0000",
                     eng_query_seq_block_valid_out, query_seq_block_rdy_out, query_info_rdy_out, eng_query_info_valid_out);
        end
        vectors++;
        if (eng_busy_out !== 4'b0000 || queries_dispatched_out !== 32'd0 || eng_num_query_blocks_out !== 16'd0) begin
            miscompares++;
            $display("FAIL rm_state: got busy=%b qd=%0d nb=%0d expected 0000 0 0",
                     eng_busy_out, queries_dispatched_out, eng_num_query_blocks_out);
        end
        query_seq_block_valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        rst                        = 1'b0;
        query_info_valid_in        = 1'b0;
        ref_length_in              = '0;
        ref_addr_in                = '0;
        num_query_blocks_in        = '0;
        query_seq_block_in         = '0;
        query_seq_block_valid_in   = 1'b0;
        eng_query_info_rdy_in      = 4'b1111;
        eng_query_seq_block_rdy_in = 4'b1111;
        eng_done_in                = 4'b0000;
        test_reset();
        test_single_query();
        test_back_to_back();
        test_zero_blocks();
        test_backpressure();
        test_set_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
